// File: rtl/hack_video_pkg.sv
// rtl/hack_video_pkg.sv - shared Hack screen geometry and VGA 640x480@60 timing constants
package hack_video_pkg;

    localparam int H_ACT_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int H_TOTAL    = H_ACT_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int H_SYNC_START = H_ACT_DEF + H_FP_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;

    localparam int V_ACT_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;
    localparam int V_TOTAL    = V_ACT_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int V_SYNC_START = V_ACT_DEF + V_FP_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

    localparam int SCREEN_W      = 512;
    localparam int SCREEN_H      = 256;
    localparam int WORDS_PER_ROW = 32;
    localparam logic [15:0] SCREEN_BASE = 16'h4000;

    typedef logic [12:0] scr_addr_t;

    // Screen RAM word address of word col on image row
    function automatic scr_addr_t scr_word_addr(input logic [7:0] row, input logic [4:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/hack_screen_scanout_if.sv
// rtl/hack_screen_scanout_if.sv - screen RAM read port between scanout and RAM
interface hack_screen_scanout_if;
    import hack_video_pkg::*;

    scr_addr_t   scr_addr;
    logic        scr_rd;
    logic [15:0] scr_data;

    modport master (output scr_addr, output scr_rd, input scr_data);
    modport slave  (input scr_addr, input scr_rd, output scr_data);
endinterface

// File: rtl/hack_video_timing.sv
// rtl/hack_video_timing.sv - pixel divider, raster counters and raw sync/blank flags
module hack_video_timing #(
    parameter int CLK_DIV = 2,
    parameter int H_ACT   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_ACT   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       ce_pix,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       h_blank,
    output logic       v_blank,
    output logic       h_sync,
    output logic       v_sync
);
    localparam int HT    = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int VT    = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div;

    assign ce_pix = (div == DIV_W'(CLK_DIV - 1));

    // Clock divider: one pixel every CLK_DIV clocks
    always_ff @(posedge clk) begin
        if (reset)       div <= '0;
        else if (ce_pix) div <= '0;
        else             div <= div + 1'b1;
    end

    // Raster position, stepped once per pixel; frame wrap coincides with line wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (ce_pix) begin
            if (h_cnt == 10'(HT - 1)) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == 10'(VT - 1)) ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign h_blank = (h_cnt >= 10'(H_ACT));
    assign v_blank = (v_cnt >= 10'(V_ACT));
    assign h_sync  = (h_cnt >= 10'(H_ACT + H_FP)) && (h_cnt < 10'(H_ACT + H_FP + H_SYNC));
    assign v_sync  = (v_cnt >= 10'(V_ACT + V_FP)) && (v_cnt < 10'(V_ACT + V_FP + V_SYNC));

endmodule

// File: rtl/hack_screen_scanout.sv
// rtl/hack_screen_scanout.sv - Hack 512x256 screen RAM reader centred in a VGA raster
module hack_screen_scanout
    import hack_video_pkg::*;
#(
    parameter int          CLK_DIV    = 2,
    parameter int          H_ACT      = H_ACT_DEF,
    parameter int          H_FP       = H_FP_DEF,
    parameter int          H_SYNC     = H_SYNC_DEF,
    parameter int          H_BP       = H_BP_DEF,
    parameter int          V_ACT      = V_ACT_DEF,
    parameter int          V_FP       = V_FP_DEF,
    parameter int          V_SYNC     = V_SYNC_DEF,
    parameter int          V_BP       = V_BP_DEF,
    parameter int          X0         = 64,
    parameter int          Y0         = 112,
    parameter logic [11:0] BORDER_RGB = 12'h222
) (
    input  logic                  clk,
    input  logic                  reset,
    hack_screen_scanout_if.master scr,
    output logic                  ce_pix,
    output logic                  HBlank,
    output logic                  VBlank,
    output logic                  HSync,
    output logic                  VSync,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b
);
    logic [9:0]  h_cnt, v_cnt;
    logic        ce, hb, vb, hs, vs;
    logic        in_win_v, in_win_h, fetch_h, load_h;
    logic [3:0]  fetch_phase, load_phase;
    logic [4:0]  fetch_word;
    logic [7:0]  row;
    logic [15:0] shifter;
    logic [11:0] pix_rgb;

    hack_video_timing #(
        .CLK_DIV(CLK_DIV),
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk     (clk),
        .reset   (reset),
        .ce_pix  (ce),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .h_blank (hb),
        .v_blank (vb),
        .h_sync  (hs),
        .v_sync  (vs)
    );

    assign ce_pix = ce;

    // A word is fetched two pixels ahead of its first pixel and loaded one pixel ahead,
    // so the load lands on the same pixel as the previous word's last bit.
    assign in_win_v    = (v_cnt >= 10'(Y0)) && (v_cnt < 10'(Y0 + SCREEN_H));
    assign in_win_h    = (h_cnt >= 10'(X0)) && (h_cnt < 10'(X0 + SCREEN_W));
    assign row         = 8'(v_cnt - 10'(Y0));
    assign fetch_phase = 4'(h_cnt + 10'd2 - 10'(X0));
    assign fetch_word  = 5'((h_cnt + 10'd2 - 10'(X0)) >> 4);
    assign load_phase  = 4'(h_cnt + 10'd1 - 10'(X0));
    assign fetch_h     = (h_cnt >= 10'(X0 - 2)) && (h_cnt <= 10'(X0 + SCREEN_W - 3)) && (fetch_phase == 4'd0);
    assign load_h      = (h_cnt >= 10'(X0 - 1)) && (h_cnt <= 10'(X0 + SCREEN_W - 2)) && (load_phase == 4'd0);

    // Colour of the current raster position; Hack pixel 1 is black
    always_comb begin
        pix_rgb = 12'h000;
        if (!hb && !vb) begin
            if (in_win_v && in_win_h) pix_rgb = shifter[0] ? 12'h000 : 12'hFFF;
            else                      pix_rgb = BORDER_RGB;
        end
    end

    // Registered video outputs, RAM fetch strobe and pixel shifter, all stepped per pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            HBlank       <= 1'b0;
            VBlank       <= 1'b0;
            HSync        <= 1'b0;
            VSync        <= 1'b0;
            vga_r        <= '0;
            vga_g        <= '0;
            vga_b        <= '0;
            scr.scr_addr <= '0;
            scr.scr_rd   <= 1'b0;
            shifter      <= '0;
        end else begin
            scr.scr_rd <= 1'b0;
            if (ce) begin
                HBlank <= hb;
                VBlank <= vb;
                HSync  <= hs;
                VSync  <= vs;
                vga_r  <= pix_rgb[11:8];
                vga_g  <= pix_rgb[7:4];
                vga_b  <= pix_rgb[3:0];
                if (in_win_v && fetch_h) begin
                    scr.scr_addr <= scr_word_addr(row, fetch_word);
                    scr.scr_rd   <= 1'b1;
                end
                if (in_win_v && load_h) shifter <= scr.scr_data;
                else                    shifter <= shifter >> 1;
            end
        end
    end

endmodule

// File: tb/tb_hack_screen_scanout.sv
// tb/tb_hack_screen_scanout.sv - randomized image scanout checked against a raster model
module tb_hack_screen_scanout;
    import hack_video_pkg::*;

    localparam int CD  = 2;
    localparam int X0  = 64;
    localparam int Y0  = 3;
    localparam int HT  = 800;
    localparam int VT  = 525;
    localparam logic [11:0] BORDER = 12'h222;
    localparam int RST_V = 20;
    localparam int RST_H = 300;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce_pix, HBlank, VBlank, HSync, VSync;
    logic [3:0] vga_r, vga_g, vga_b;

    hack_screen_scanout_if bus();

    hack_screen_scanout #(
        .CLK_DIV(CD), .X0(X0), .Y0(Y0), .BORDER_RGB(BORDER)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .scr    (bus),
        .ce_pix (ce_pix),
        .HBlank (HBlank),
        .VBlank (VBlank),
        .HSync  (HSync),
        .VSync  (VSync),
        .vga_r  (vga_r),
        .vga_g  (vga_g),
        .vga_b  (vga_b)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:8191];

    always @(posedge clk) begin
        if (reset)           bus.scr_data <= 16'h0000;
        else if (bus.scr_rd) bus.scr_data <= mem[bus.scr_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int j = 0;
    always @(posedge clk) begin
        if (reset) j <= 0;
        else       j <= j + 1;
    end

    bit checking = 1'b0;
    int exp_addr = 0;
    int rd_cnt = 0;
    int early_rd = 0;

    always @(negedge clk) begin
        if (checking) begin
            int p, h, v, w_exp, rgb_exp, rgb_act;
            bit ce_edge, fetch, hb, vb, hs, vs;
            rgb_act = int'({vga_r, vga_g, vga_b});
            if (j == 0) begin
                exp_addr = 0;
                rd_cnt   = 0;
                early_rd = 0;
            end
            ce_edge = (j >= CD) && (j % CD == 0);
            if (j < CD) begin
                h = -1; v = -1;
                hb = 0; vb = 0; hs = 0; vs = 0; rgb_exp = 0; fetch = 0;
            end else begin
                p  = j / CD - 1;
                h  = p % HT;
                v  = (p / HT) % VT;
                hb = (h >= 640);
                vb = (v >= 480);
                hs = (h >= 656) && (h <= 751);
                vs = (v >= 490) && (v <= 491);
                if (hb || vb) rgb_exp = 0;
                else if (v >= Y0 && v < Y0 + 256 && h >= X0 && h < X0 + 512) begin
                    w_exp   = int'(mem[(v - Y0) * 32 + (h - X0) / 16]);
                    rgb_exp = ((w_exp >> ((h - X0) % 16)) & 1) ? 0 : 12'hFFF;
                end else rgb_exp = int'(BORDER);
                fetch = ce_edge && v >= Y0 && v < Y0 + 256 && h >= X0 - 2 && h <= X0 + 509
                        && ((h - X0 + 2) % 16 == 0);
                if (fetch) exp_addr = (v - Y0) * 32 + (h - X0 + 2) / 16;
            end
            chk("ce_pix", int'(ce_pix), int'(j % CD == CD - 1));
            chk("HBlank", int'(HBlank), int'(hb));
            chk("VBlank", int'(VBlank), int'(vb));
            chk("HSync", int'(HSync), int'(hs));
            chk("VSync", int'(VSync), int'(vs));
            chk("rgb", rgb_act, rgb_exp);
            chk("scr_rd", int'(bus.scr_rd), int'(fetch));
            chk("scr_addr", int'(bus.scr_addr), exp_addr);

            if (ce_edge) begin
                if (v == Y0 && h == 64)  chk("lit_first_px_black", rgb_act, 0);
                if (v == Y0 && h == 65)  chk("lit_second_px_white", rgb_act, 12'hFFF);
                if (v == Y0 && h == 575) chk("lit_last_px_white", rgb_act, 12'hFFF);
                if (v == Y0 && h == 63)  chk("lit_left_border", rgb_act, 12'h222);
                if (v == Y0 && h == 576) chk("lit_right_border", rgb_act, 12'h222);
                if (v == Y0 + 1 && h == 575) chk("lit_row1_last_px", rgb_act,
                    mem[63][15] ? 0 : 12'hFFF);
                if (v == 0 && h == 655)  chk("lit_hsync_before", int'(HSync), 0);
                if (v == 0 && h == 656)  chk("lit_hsync_start", int'(HSync), 1);
                if (v == 0 && h == 751)  chk("lit_hsync_end", int'(HSync), 1);
                if (v == 0 && h == 752)  chk("lit_hsync_after", int'(HSync), 0);
                if (v == 1 && h == 640)  chk("lit_hblank_rgb", int'({HBlank, vga_r, vga_g, vga_b}), 16'h1000);
                if (v == Y0 && h == 0)   chk("lit_no_rd_before_window", early_rd, 0);
                if (v == Y0 + 1 && h == HT - 1) chk("lit_row1_rd_count", rd_cnt, 32);
            end
            if (bus.scr_rd && j >= CD) begin
                if (v < Y0) early_rd++;
                if (v == Y0 + 1) begin
                    chk("lit_row1_addr", int'(bus.scr_addr), 32 + rd_cnt);
                    chk("lit_row1_rd_h", h, 62 + 16 * rd_cnt);
                    rd_cnt++;
                end
            end
        end
    end

    initial begin
        int tgt;
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
        mem[0]    = 16'h0001;
        mem[8191] = 16'h8000;

        reset = 1'b1;
        @(negedge clk);
        checking = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        tgt = CD * (RST_V * HT + RST_H + 1);
        for (int i = 0; i < 60000 && j != tgt; i++) @(negedge clk);
        chk("reach_reset_point", j, tgt);

        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_outputs", int'({ce_pix, HBlank, VBlank, HSync, VSync, vga_r, vga_g, vga_b,
                                       bus.scr_rd, bus.scr_addr}), 0);
        chk("mid_reset_counter", j, 0);
        reset = 1'b0;

        repeat (CD * HT * 8 + 50) @(negedge clk);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
